// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB manager between N_REQ request/response FIFO pairs
module apb_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int REQ_PKT_W  = 64,
  parameter int RESP_PKT_W = 48,
  parameter int IDX_W      = $clog2(N_REQ)
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [N_REQ-1:0]           req_empty_i,
  input  logic [N_REQ*REQ_PKT_W-1:0] req_pkt_i,
  output logic [N_REQ-1:0]           req_rreq_o,
  input  logic [N_REQ-1:0]           resp_full_i,
  output logic [N_REQ-1:0]           resp_wreq_o,
  output logic [RESP_PKT_W-1:0]      resp_pkt_o,
  output logic                       mgr_fifo_empty_o,
  output logic [REQ_PKT_W-1:0]       mgr_in_pkt_o,
  input  logic                       mgr_fifo_rreq_i,
  output logic                       mgr_fifo_full_o,
  input  logic [RESP_PKT_W-1:0]      mgr_out_pkt_i,
  input  logic                       mgr_fifo_wreq_i,
  output logic [IDX_W-1:0]           grant_idx_o,
  output logic                       busy_o,
  output logic [15:0]                txn_cnt_o
);
  typedef enum logic [1:0] {ARB_IDLE, GRANT, CAPTURE, WAIT_RESP} state_e;
  state_e                 r_state;
  logic [IDX_W-1:0]       r_grant;
  logic [IDX_W-1:0]       w_next;
  logic [IDX_W-1:0]       w_idx;
  logic [REQ_PKT_W-1:0]   r_pkt;
  logic [REQ_PKT_W-1:0]   w_sel_pkt;
  logic [15:0]            r_cnt;
  logic                   w_push;
  logic [N_REQ-1:0]       w_grant_oh;

  assign w_sel_pkt  = req_pkt_i[r_grant*REQ_PKT_W +: REQ_PKT_W];
  assign w_grant_oh = N_REQ'(1) << r_grant;
  assign w_push     = (r_state == WAIT_RESP) & mgr_fifo_wreq_i & ~resp_full_i[r_grant];

  // next grant: first non-empty requester after the last one granted, wrapping; lowest offset wins
  always_comb begin
    w_next = r_grant;
    w_idx  = r_grant;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(r_grant) + k) % N_REQ);
      if (!req_empty_i[w_idx]) w_next = w_idx;
    end
  end

  assign req_rreq_o       = (r_state == GRANT && mgr_fifo_rreq_i) ? w_grant_oh : '0;
  assign resp_wreq_o      = w_push ? w_grant_oh : '0;
  assign resp_pkt_o       = (r_state == WAIT_RESP) ? mgr_out_pkt_i : '0;
  assign mgr_fifo_empty_o = (r_state == GRANT) ? req_empty_i[r_grant] : 1'b1;
  assign mgr_fifo_full_o  = (r_state == WAIT_RESP) ? resp_full_i[r_grant] : 1'b1;
  assign mgr_in_pkt_o     = (r_state == CAPTURE) ? w_sel_pkt : (r_state == WAIT_RESP) ? r_pkt : '0;
  assign grant_idx_o      = r_grant;
  assign busy_o           = r_state != ARB_IDLE;
  assign txn_cnt_o        = r_cnt;

  // arbitration FSM: grant is locked from selection until the granted requester's response is accepted
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ARB_IDLE;
      r_grant <= IDX_W'(N_REQ - 1);
      r_pkt   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: if (!(&req_empty_i)) begin
          r_grant <= w_next;
          r_state <= GRANT;
        end
        GRANT: if (mgr_fifo_rreq_i) r_state <= CAPTURE;
          else if (req_empty_i[r_grant]) r_state <= ARB_IDLE;
        CAPTURE: begin
          r_pkt   <= w_sel_pkt;
          r_state <= WAIT_RESP;
        end
        WAIT_RESP: if (w_push) begin
          r_cnt   <= r_cnt + 16'd1;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one apb_manager between N_REQ requester-side request/response FIFO pairs, e.g. several NI ports behind one APB bridge.
- Presents a single virtual request FIFO and a single virtual response FIFO to the manager.
- Picks requesters round-robin, locks the grant from request read until the matching response push, and captures and holds the request packet.
- Steers the manager's response packet and write strobe to the granted requester's response FIFO.

Parameters:
N_REQ, 4, number of requesters (2..16)
REQ_PKT_W, 64, width of the request packet (packed req_packet_s)
RESP_PKT_W, 48, width of the response packet (packed resp_packet_s)
IDX_W, $clog2(N_REQ), derived; width of the grant index

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  asynchronous, active-low reset
req_empty_i  in  N_REQ  per-requester request FIFO empty
req_pkt_i  in  N_REQ*REQ_PKT_W  per-requester request FIFO read data, valid the cycle after its read strobe; slice i = requester i
req_rreq_o  out  N_REQ  per-requester request FIFO read strobe
resp_full_i  in  N_REQ  per-requester response FIFO full
resp_wreq_o  out  N_REQ  per-requester response FIFO write strobe
resp_pkt_o  out  RESP_PKT_W  response data, shared by all response FIFOs
mgr_fifo_empty_o  out  1  drives the manager's fifo_empty
mgr_in_pkt_o  out  REQ_PKT_W  drives the manager's in_trans_pkt
mgr_fifo_rreq_i  in  1  the manager's fifo_rreq
mgr_fifo_full_o  out  1  drives the manager's fifo_full
mgr_out_pkt_i  in  RESP_PKT_W  the manager's out_trans_pkt
mgr_fifo_wreq_i  in  1  the manager's fifo_wreq
grant_idx_o  out  IDX_W  current or last granted requester
busy_o  out  1  transaction in flight (state != ARB_IDLE)
txn_cnt_o  out  16  completed-transaction counter

Behaviour:
- Reset (asynchronous) values:
  - state = ARB_IDLE, grant_idx_o = N_REQ-1, so requester 0 has first priority.
  - pkt_q = 0, txn_cnt_o = 0, busy_o = 0.
  - req_rreq_o = 0, resp_wreq_o = 0, resp_pkt_o = 0.
  - mgr_fifo_empty_o = 1, mgr_fifo_full_o = 1, mgr_in_pkt_o = 0.
- Outputs are combinational from state and registers. No output drives another output combinationally except the strobe pass-throughs listed below.
- ARB_IDLE:
  - Drive mgr_fifo_empty_o = 1 and mgr_fifo_full_o = 1.
  - If any req_empty_i bit is 0: register grant_idx = first non-empty index searching grant_idx+1, +2, ... modulo N_REQ, then go to GRANT.
  - Selection takes 1 cycle.
- GRANT:
  - Drive mgr_fifo_empty_o = req_empty_i[grant_idx].
  - req_rreq_o[grant_idx] = mgr_fifo_rreq_i, same-cycle pass-through; all other req_rreq_o bits stay 0.
  - On mgr_fifo_rreq_i, go to CAPTURE.
  - If req_empty_i[grant_idx] goes to 1 with no rreq (requester flushed), go to ARB_IDLE. grant_idx is kept, so that requester becomes lowest priority.
- CAPTURE (exactly 1 cycle; this is the manager's SETUP cycle):
  - mgr_in_pkt_o = req_pkt_i slice grant_idx, direct.
  - Register that slice into pkt_q at the clock edge.
  - Drive mgr_fifo_empty_o = 1, then go to WAIT_RESP.
- WAIT_RESP:
  - mgr_in_pkt_o = pkt_q, held stable.
  - mgr_fifo_empty_o = 1.
  - mgr_fifo_full_o = resp_full_i[grant_idx].
  - resp_pkt_o = mgr_out_pkt_i.
  - resp_wreq_o[grant_idx] = mgr_fifo_wreq_i & ~resp_full_i[grant_idx].
  - On that accepted write: txn_cnt_o += 1 (wraps 0xFFFF -> 0), then go to ARB_IDLE.
- Outside WAIT_RESP:
  - A mgr_fifo_wreq_i pulse is ignored: no resp_wreq_o, no counter change.
  - mgr_fifo_rreq_i outside GRANT produces no req_rreq_o.
- Only one transaction is in flight at a time.
- Minimum cycles per transaction, ARB_IDLE to ARB_IDLE with PREADY = 1 and no backpressure: 1 (select) + manager sequence, plus 1 return cycle.
- Simultaneous requests are resolved by round-robin only. No requester waits more than N_REQ-1 transactions.
- Reset asserted mid-transaction returns everything to the reset values immediately. No req_rreq_o or resp_wreq_o pulse is emitted.

Test Plan:
1. Only requester 2 non-empty, slice 2 data 0x0000_0000_0000_A5A5 appearing after rreq -> req_rreq_o = 4'b0100 for 1 cycle; mgr_in_pkt_o = 0x...A5A5 from CAPTURE until the push; resp_wreq_o = 4'b0100 with resp_pkt_o = mgr_out_pkt_i; txn_cnt_o = 1.
2. All 4 requesters hold 2 packets each from reset -> grant order 0,1,2,3,0,1,2,3; txn_cnt_o = 8; no req_rreq_o bit ever pulses twice without an intervening push.
3. resp_full_i[1] = 1 for 10 cycles while requester 1 waits in WAIT_RESP -> mgr_fifo_full_o = 1; no resp_wreq_o; the push occurs the cycle after full drops; busy_o stays 1 throughout.
4. Spurious mgr_fifo_wreq_i pulse in ARB_IDLE, and mgr_fifo_rreq_i pulse in WAIT_RESP -> resp_wreq_o = 0, req_rreq_o = 0, txn_cnt_o unchanged.
5. PRESETn pulsed low during WAIT_RESP for requester 3 -> busy_o = 0 and grant_idx_o = 3 asynchronously; after release with all requesters non-empty, requester 0 is granted first.
6. Requester 1 granted, then req_empty_i[1] rises before any rreq -> return to ARB_IDLE with no read; next grant goes to requester 2 if it is non-empty.
